// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for the shared 4-to-1 mux. It owns the mux select and
// registers the granted word into a single-entry output stage.
//
// state | meaning
// IDLE  | output register empty
// HOLD  | output register holds a word waiting for out_ready
module mux4_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_data2,
  input  logic [WIDTH-1:0] req_data3,
  output logic [3:0]       req_ready,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             can_accept;
  logic             grant_vld;
  logic [1:0]       grant_idx;
  logic [1:0]       scan_idx;
  logic             take;
  logic [WIDTH-1:0] grant_data;

  // Scan starting at ptr; the first valid requester in rotation wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'b00;
    scan_idx  = 2'b00;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!grant_vld && req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    case (grant_idx)
      2'd0:    grant_data = req_data0;
      2'd1:    grant_data = req_data1;
      2'd2:    grant_data = req_data2;
      default: grant_data = req_data3;
    endcase
  end

  assign can_accept = (state_q == IDLE) || out_ready;
  // The rst term keeps req_ready low while reset is asserted, even with requests pending.
  assign take       = grant_vld && can_accept && !rst;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (take) begin
      out_data_d  = grant_data;
      sel_d       = grant_idx;
      ptr_d       = grant_idx + 2'd1;
      out_valid_d = 1'b1;
      state_d     = HOLD;
    end else if ((state_q == HOLD) && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'b00;
      sel_q       <= 2'b00;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign req_ready = take ? (4'b0001 << grant_idx) : 4'b0000;
  assign sel       = sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = out_valid_q | (|req_valid);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, single request, rotation,
// backpressure, pointer wrap and reset during HOLD.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_valid;
  logic [7:0] req_data0, req_data1, req_data2, req_data3;
  logic [3:0] req_ready;
  logic [1:0] sel;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;

  int total;
  int bad;

  mux4_rr_arbiter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_data2 (req_data2),
    .req_data3 (req_data3),
    .req_ready (req_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rr_data [5];
  logic [1:0] rr_sel  [5];
  logic [3:0] rr_rdy  [5];

  initial begin
    total = 0;
    bad   = 0;
    rr_data = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    rr_sel  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rr_rdy  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst = 1'b1;
    req_valid = 4'b1111;
    req_data0 = 8'h10; req_data1 = 8'h11; req_data2 = 8'hA5; req_data3 = 8'h13;
    out_ready = 1'b1;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_sel",       32'(sel),       32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy",      32'(busy),      32'd1);
    req_valid = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);

    // Single request from requester 2
    tick();
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(req_ready), 32'b0100);
    tick();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data",  32'(out_data),  32'hA5);
    chk("single_sel",   32'(sel),       32'd2);
    req_valid = 4'b0000;
    #1;
    chk("single_no_grant", 32'(req_ready), 32'd0);
    tick();
    chk("single_drain", 32'(out_valid), 32'd0);
    chk("single_sel_kept", 32'(sel), 32'd2);

    // Asynchronous reset between edges restores ptr to 0
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sel", 32'(sel), 32'd0);
    #1 rst = 1'b0;

    // Round robin with all requesters valid
    tick();
    req_data2 = 8'h12;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("rr_ready%0d", i), 32'(req_ready), 32'(rr_rdy[i]));
      tick();
      chk($sformatf("rr_data%0d", i), 32'(out_data), 32'(rr_data[i]));
      chk($sformatf("rr_sel%0d", i),  32'(sel),      32'(rr_sel[i]));
      chk($sformatf("rr_valid%0d", i), 32'(out_valid), 32'd1);
    end

    // Backpressure: hold the word, grant nothing
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_ready%0d", i), 32'(req_ready), 32'd0);
      tick();
      chk($sformatf("bp_data%0d", i),  32'(out_data),  32'h10);
      chk($sformatf("bp_sel%0d", i),   32'(sel),       32'd0);
      chk($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b0010);
    tick();
    chk("bp_release_data", 32'(out_data), 32'h11);
    chk("bp_release_sel",  32'(sel),      32'd1);

    // Pointer wraps from 2 past 2,3 to requester 0, then 1
    req_valid = 4'b0011;
    #1;
    chk("skip_ready0", 32'(req_ready), 32'b0001);
    tick();
    chk("skip_data0", 32'(out_data), 32'h10);
    chk("skip_sel0",  32'(sel),      32'd0);
    #1;
    chk("skip_ready1", 32'(req_ready), 32'b0010);
    tick();
    chk("skip_data1", 32'(out_data), 32'h11);
    chk("skip_sel1",  32'(sel),      32'd1);
    req_valid = 4'b0000;
    tick();
    chk("skip_drain", 32'(out_valid), 32'd0);
    chk("skip_busy",  32'(busy),      32'd0);

    // Reset while holding a word under backpressure
    req_data2 = 8'hA5;
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    out_ready = 1'b0;
    tick();
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_data",  32'(out_data),  32'hA5);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data",  32'(out_data),  32'd0);
    chk("midrst_sel",   32'(sel),       32'd0);
    #1 rst = 1'b0;
    req_valid = 4'b1010;
    out_ready = 1'b1;
    #1;
    chk("restart_ready", 32'(req_ready), 32'b0010);
    tick();
    chk("restart_data", 32'(out_data), 32'h11);
    chk("restart_sel",  32'(sel),      32'd1);
    req_valid = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
